// File: rtl/meas_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : meas_cmd_scheduler
//  Description : Automatic-mode controller for the frequency counter. Pops
//                command bytes from the host command FIFO, decodes them into
//                period/interval settings and start/stop/single-shot
//                controls, and drives the measurement gate of the counting
//                datapath.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TICK_CYCLES   sys_clk cycles per time unit (28-bit range)
//    DEF_PERIOD    reset value of cfg_period, in ticks (1..9)
//    DEF_INTERVAL  reset value of cfg_interval, in ticks (1..19)
//  Ports
//    sys_clk       system clock
//    sys_rst       asynchronous active-low reset
//    sched_en      1 = automatic mode; 0 = no pops, scheduler forced idle
//    fifo_empty    command FIFO empty flag
//    fifo_dout     FIFO read data, valid the cycle after fifo_rd_en
//    fifo_rd_en    one-cycle FIFO pop strobe
//    meas_gate     counter enable, high for the whole measurement window
//    meas_done     one-cycle pulse on the first gate-low cycle of a window
//                  that completed normally
//    busy          high whenever the scheduler is not idle
//    cfg_period    current period setting, in ticks
//    cfg_interval  current interval setting, in ticks
//    err_cnt       (SEQ_ERR_CNT_EN only) saturating count of unknown
//                  opcodes and out-of-range arguments
//  Build option
//    SEQ_ERR_CNT_EN  define to add the err_cnt output and its counter
// ============================================================================
module meas_cmd_scheduler #(
   parameter int unsigned TICK_CYCLES  = 50_000_000,
   parameter int unsigned DEF_PERIOD   = 1,
   parameter int unsigned DEF_INTERVAL = 10
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       sched_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rd_en,
   output logic       meas_gate,
   output logic       meas_done,
   output logic       busy,
   output logic [3:0] cfg_period,
   output logic [4:0] cfg_interval
`ifdef SEQ_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam logic [7:0]  c_op_set_interval = 8'h01;
   localparam logic [7:0]  c_op_set_period   = 8'h02;
   localparam logic [7:0]  c_op_start        = 8'h03;
   localparam logic [7:0]  c_op_stop         = 8'h04;
   localparam logic [7:0]  c_op_single       = 8'h05;
   localparam logic [27:0] c_tick_last       = 28'(TICK_CYCLES - 1);
   localparam logic [3:0]  c_def_period      = 4'(DEF_PERIOD);
   localparam logic [4:0]  c_def_interval    = 5'(DEF_INTERVAL);

   typedef enum logic [2:0] {
      P_IDLE   = 3'd0,
      P_OPW    = 3'd1,
      P_ARGREQ = 3'd2,
      P_ARGW   = 3'd3,
      P_EXEC   = 3'd4
   } p_state_t;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_GATE = 2'd1,
      M_GAP  = 2'd2
   } m_state_t;

   // ------------------------------------------------------------------------
   // Command parser
   // ------------------------------------------------------------------------
   p_state_t   p_state_q, p_state_d;
   logic [7:0] op_q, op_d;
   logic [7:0] arg_q, arg_d;
   logic [3:0] cfg_period_q, cfg_period_d;
   logic [4:0] cfg_interval_q, cfg_interval_d;
   logic       rd_req;
   logic       op_known;
   logic       per_arg_ok;
   logic       int_arg_ok;
   logic       cmd_start;
   logic       cmd_stop;
   logic       cmd_single;

   always_comb begin
      op_known   = (fifo_dout >= c_op_set_interval) && (fifo_dout <= c_op_single);
      per_arg_ok = (arg_q >= 8'd1) && (arg_q <= 8'd9);
      int_arg_ok = (arg_q >= 8'd1) && (arg_q <= 8'd19);
   end

   always_comb begin
      p_state_d      = p_state_q;
      op_d           = op_q;
      arg_d          = arg_q;
      cfg_period_d   = cfg_period_q;
      cfg_interval_d = cfg_interval_q;
      rd_req         = 1'b0;
      cmd_start      = 1'b0;
      cmd_stop       = 1'b0;
      cmd_single     = 1'b0;

      case (p_state_q)
         P_IDLE: begin
            if (sched_en && !fifo_empty) begin
               rd_req    = 1'b1;
               p_state_d = P_OPW;
            end
         end
         P_OPW: begin
            op_d = fifo_dout;
            if ((fifo_dout == c_op_set_interval) || (fifo_dout == c_op_set_period)) begin
               p_state_d = P_ARGREQ;
            end else if (op_known) begin
               p_state_d = P_EXEC;
            end else begin
               p_state_d = P_IDLE;
            end
         end
         P_ARGREQ: begin
            // A half-read command parks here while automatic mode is off.
            if (sched_en && !fifo_empty) begin
               rd_req    = 1'b1;
               p_state_d = P_ARGW;
            end
         end
         P_ARGW: begin
            arg_d     = fifo_dout;
            p_state_d = P_EXEC;
         end
         P_EXEC: begin
            p_state_d = P_IDLE;
            case (op_q)
               c_op_set_interval: if (int_arg_ok) cfg_interval_d = arg_q[4:0];
               c_op_set_period:   if (per_arg_ok) cfg_period_d   = arg_q[3:0];
               c_op_start:        cmd_start  = 1'b1;
               c_op_stop:         cmd_stop   = 1'b1;
               c_op_single:       cmd_single = 1'b1;
               default:           ;
            endcase
         end
         default: p_state_d = P_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         p_state_q      <= P_IDLE;
         op_q           <= 8'h00;
         arg_q          <= 8'h00;
         cfg_period_q   <= c_def_period;
         cfg_interval_q <= c_def_interval;
      end else begin
         p_state_q      <= p_state_d;
         op_q           <= op_d;
         arg_q          <= arg_d;
         cfg_period_q   <= cfg_period_d;
         cfg_interval_q <= cfg_interval_d;
      end
   end

   // The strobe is combinational from the parser state; holding it low while
   // reset is asserted keeps the FIFO from losing a byte during reset.
   assign fifo_rd_en   = rd_req & sys_rst;
   assign cfg_period   = cfg_period_q;
   assign cfg_interval = cfg_interval_q;

   // ------------------------------------------------------------------------
   // Measurement scheduler
   // ------------------------------------------------------------------------
   m_state_t    m_state_q, m_state_d;
   logic        cont_q, cont_d;
   logic [27:0] cyc_q, cyc_d;
   logic [4:0]  tick_q, tick_d;
   logic [3:0]  win_period_q, win_period_d;
   logic [4:0]  win_interval_q, win_interval_d;
   logic        done_q, done_d;
   logic        tick_wrap;

   always_comb begin
      m_state_d      = m_state_q;
      cont_d         = cont_q;
      cyc_d          = cyc_q + 28'd1;
      tick_d         = tick_q;
      win_period_d   = win_period_q;
      win_interval_d = win_interval_q;
      done_d         = 1'b0;
      tick_wrap      = (cyc_q == c_tick_last);

      if (tick_wrap) begin
         cyc_d  = 28'd0;
         tick_d = tick_q + 5'd1;
      end

      if (cmd_start)  cont_d = 1'b1;
      if (cmd_single) cont_d = 1'b0;

      case (m_state_q)
         M_IDLE: begin
            cyc_d  = 28'd0;
            tick_d = 5'd0;
            if (cmd_start || cmd_single) begin
               m_state_d      = M_GATE;
               win_period_d   = cfg_period_q;
               win_interval_d = cfg_interval_q;
            end
         end
         M_GATE: begin
            if (tick_wrap && (tick_q == ({1'b0, win_period_q} - 5'd1))) begin
               done_d    = 1'b1;
               cyc_d     = 28'd0;
               tick_d    = 5'd0;
               // Uses the flag after this cycle's command, so a SINGLE that
               // lands on the last gate cycle still ends the run.
               m_state_d = cont_d ? M_GAP : M_IDLE;
            end
         end
         M_GAP: begin
            if (tick_wrap && (tick_q == (win_interval_q - 5'd1))) begin
               m_state_d      = M_GATE;
               cyc_d          = 28'd0;
               tick_d         = 5'd0;
               win_period_d   = cfg_period_q;
               win_interval_d = cfg_interval_q;
            end
         end
         default: m_state_d = M_IDLE;
      endcase

      // Abort path: no completion pulse, run flag cleared.
      if (cmd_stop || !sched_en) begin
         m_state_d = M_IDLE;
         cont_d    = 1'b0;
         done_d    = 1'b0;
         cyc_d     = 28'd0;
         tick_d    = 5'd0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         m_state_q      <= M_IDLE;
         cont_q         <= 1'b0;
         cyc_q          <= 28'd0;
         tick_q         <= 5'd0;
         win_period_q   <= c_def_period;
         win_interval_q <= c_def_interval;
         done_q         <= 1'b0;
      end else begin
         m_state_q      <= m_state_d;
         cont_q         <= cont_d;
         cyc_q          <= cyc_d;
         tick_q         <= tick_d;
         win_period_q   <= win_period_d;
         win_interval_q <= win_interval_d;
         done_q         <= done_d;
      end
   end

   assign meas_gate = (m_state_q == M_GATE);
   assign busy      = (m_state_q != M_IDLE);
   assign meas_done = done_q;

`ifdef SEQ_ERR_CNT_EN
   // ------------------------------------------------------------------------
   // Invalid-command counter
   // ------------------------------------------------------------------------
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       bad_op;
   logic       bad_arg;

   always_comb begin
      bad_op    = (p_state_q == P_OPW) && !op_known;
      bad_arg   = (p_state_q == P_EXEC) &&
                  (((op_q == c_op_set_interval) && !int_arg_ok) ||
                   ((op_q == c_op_set_period)   && !per_arg_ok));
      err_cnt_d = err_cnt_q;
      if ((bad_op || bad_arg) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_meas_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_meas_cmd_scheduler
//  Description : Scoreboard bench for meas_cmd_scheduler. The stimulus
//                process owns a byte-queue FIFO model and pushes expected
//                gate windows / gaps; a monitor measures the gate waveform
//                and compares each observed window or gap in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_cmd_scheduler;

   localparam int unsigned TICK = 10;

   logic       sys_clk;
   logic       sys_rst;
   logic       sched_en;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rd_en;
   logic       meas_gate;
   logic       meas_done;
   logic       busy;
   logic [3:0] cfg_period;
   logic [4:0] cfg_interval;
`ifdef SEQ_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   meas_cmd_scheduler #(
      .TICK_CYCLES  (TICK),
      .DEF_PERIOD   (1),
      .DEF_INTERVAL (10)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .sched_en     (sched_en),
      .fifo_empty   (fifo_empty),
      .fifo_dout    (fifo_dout),
      .fifo_rd_en   (fifo_rd_en),
      .meas_gate    (meas_gate),
      .meas_done    (meas_done),
      .busy         (busy),
      .cfg_period   (cfg_period),
      .cfg_interval (cfg_interval)
`ifdef SEQ_ERR_CNT_EN
      ,
      .err_cnt      (err_cnt)
`endif
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic        is_gap;
      logic [15:0] len;
      logic        done;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] fifo_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_pops   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_ev(input logic is_gap, input int len, input logic done);
      ev_t e;
      e.is_gap = is_gap;
      e.len    = 16'(len);
      e.done   = done;
      exp_q.push_back(e);
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge. The FIFO pops on
   // the rising edge when the strobe was high; data appears just after it.
   task automatic cyc();
      logic rd;
      #1;
      rd = fifo_rd_en;
      if (rd) begin
         n_pops++;
         check("rd_en_while_empty", fifo_empty, 0);
      end
      @(posedge sys_clk);
      #1;
      if (rd && (fifo_q.size() > 0)) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      @(negedge sys_clk);
   endtask

   task automatic wait_gate(input logic lvl, input int budget, input string name);
      int n;
      n = 0;
      while ((meas_gate !== lvl) && (n < budget)) begin
         cyc();
         n++;
      end
      check(name, meas_gate, lvl);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((busy !== 1'b0) && (n < budget)) begin
         cyc();
         n++;
      end
      check(name, busy, 0);
   endtask

   task automatic ncyc(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // ------------------------------------------------------------------------
   // Monitor: measures gate-high windows and busy gate-low gaps
   // ------------------------------------------------------------------------
   logic mon_prev   = 1'b0;
   int   mon_hi     = 0;
   int   mon_lo     = 0;
   logic mon_gap_ok = 1'b0;

   task automatic compare_ev(input logic is_gap, input int len, input logic done);
      ev_t e;
      if (exp_q.size() == 0) begin
         check(is_gap ? "unexpected_gap" : "unexpected_window", 32'(len), 0);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", is_gap, e.is_gap);
         check(is_gap ? "gap_len" : "window_len", 32'(len), 32'(e.len));
         if (!is_gap) check("meas_done_at_fall", done, e.done);
      end
   endtask

   initial begin
      forever begin
         @(negedge sys_clk);
         if (!sys_rst) begin
            mon_prev   = 1'b0;
            mon_hi     = 0;
            mon_lo     = 0;
            mon_gap_ok = 1'b0;
         end else begin
            if (meas_gate) begin
               if (!mon_prev && mon_gap_ok) compare_ev(1'b1, mon_lo, 1'b0);
               mon_gap_ok = 1'b0;
               mon_hi++;
            end else begin
               if (mon_prev) begin
                  compare_ev(1'b0, mon_hi, meas_done);
                  mon_hi     = 0;
                  mon_lo     = 0;
                  mon_gap_ok = 1'b1;
               end else if (meas_done) begin
                  check("stray_meas_done", meas_done, 0);
               end
               if (!busy) mon_gap_ok = 1'b0;
               if (mon_gap_ok) mon_lo++;
            end
            mon_prev = meas_gate;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      sys_rst    = 1'b0;
      sched_en   = 1'b1;
      fifo_empty = 1'b1;
      fifo_dout  = 8'h00;
      repeat (3) @(negedge sys_clk);

      check("rst_fifo_rd_en", fifo_rd_en, 0);
      check("rst_meas_gate", meas_gate, 0);
      check("rst_meas_done", meas_done, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_period", cfg_period, 1);
      check("rst_cfg_interval", cfg_interval, 10);
`ifdef SEQ_ERR_CNT_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      sys_rst = 1'b1;
      ncyc(2);

      // Single shot, default period of one tick.
      n_pops = 0;
      expect_ev(1'b0, 10, 1'b1);
      push_byte(8'h05);
      ncyc(2);
      check("gate_low_during_exec", meas_gate, 0);
      cyc();
      check("gate_rise_after_exec", meas_gate, 1);
      wait_idle(50, "single_ends_idle");
      ncyc(3);
      check("single_pops", n_pops, 1);
      check("single_busy_after", busy, 0);

      // Period 3, interval 2, continuous; then STOP in the third window.
      n_pops = 0;
      expect_ev(1'b0, 30, 1'b1);
      expect_ev(1'b1, 20, 1'b0);
      expect_ev(1'b0, 30, 1'b1);
      expect_ev(1'b1, 20, 1'b0);
      expect_ev(1'b0, 7, 1'b0);
      push_byte(8'h02); push_byte(8'h03);
      push_byte(8'h01); push_byte(8'h02);
      push_byte(8'h03);
      wait_gate(1'b1, 40, "cont_w1_rise");
      check("cfg_period_3", cfg_period, 3);
      check("cfg_interval_2", cfg_interval, 2);
      wait_gate(1'b0, 40, "cont_w1_fall");
      wait_gate(1'b1, 40, "cont_w2_rise");
      wait_gate(1'b0, 40, "cont_w2_fall");
      wait_gate(1'b1, 40, "cont_w3_rise");
      ncyc(4);
      push_byte(8'h04);
      ncyc(2);
      check("gate_high_during_stop_exec", meas_gate, 1);
      cyc();
      check("gate_low_after_stop", meas_gate, 0);
      check("busy_low_after_stop", busy, 0);
      check("cont_pops", n_pops, 6);
      ncyc(3);

      // Mid-window SET_PERIOD 5 only affects the next window; SINGLE ends run.
      expect_ev(1'b0, 30, 1'b1);
      expect_ev(1'b1, 20, 1'b0);
      expect_ev(1'b0, 50, 1'b1);
      push_byte(8'h03);
      wait_gate(1'b1, 20, "mid_w1_rise");
      ncyc(4);
      push_byte(8'h02); push_byte(8'h05);
      wait_gate(1'b0, 40, "mid_w1_fall");
      check("cfg_period_5", cfg_period, 5);
      wait_gate(1'b1, 40, "mid_w2_rise");
      ncyc(4);
      push_byte(8'h05);
      wait_idle(100, "single_ends_run");
      ncyc(30);
      check("no_restart_after_single", busy, 0);

      // Automatic mode off: a queued byte is not popped.
      sched_en = 1'b0;
      n_pops   = 0;
      push_byte(8'h05);
      ncyc(8);
      check("disabled_no_pops", n_pops, 0);
      check("disabled_busy", busy, 0);

      // Re-enable, then drop automatic mode mid-gate.
      expect_ev(1'b0, 5, 1'b0);
      sched_en = 1'b1;
      wait_gate(1'b1, 20, "reenable_rise");
      ncyc(4);
      sched_en = 1'b0;
      cyc();
      check("gate_low_after_disable", meas_gate, 0);
      check("busy_low_after_disable", busy, 0);
      ncyc(3);

      // Half-read command stalls waiting for its argument while disabled.
      sched_en = 1'b1;
      n_pops   = 0;
      push_byte(8'h02);
      ncyc(4);
      sched_en = 1'b0;
      push_byte(8'h04);
      ncyc(5);
      check("stall_pops", n_pops, 1);
      check("stall_cfg_period", cfg_period, 5);
      sched_en = 1'b1;
      ncyc(5);
      check("resume_pops", n_pops, 2);
      check("resume_cfg_period", cfg_period, 4);

      // Asynchronous reset in the middle of a window.
      push_byte(8'h05);
      wait_gate(1'b1, 20, "rst_test_rise");
      ncyc(3);
      #2;
      sys_rst = 1'b0;
      #1;
      check("async_rst_gate", meas_gate, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", meas_done, 0);
      check("async_rst_rd_en", fifo_rd_en, 0);
      check("async_rst_cfg_period", cfg_period, 1);
      check("async_rst_cfg_interval", cfg_interval, 10);
      @(negedge sys_clk);
      ncyc(2);
      sys_rst = 1'b1;
      cyc();

      // Out-of-range arguments and an unknown opcode.
      n_pops = 0;
      push_byte(8'h02); push_byte(8'h0A);
      push_byte(8'h01); push_byte(8'h00);
      push_byte(8'h07);
      ncyc(20);
      check("bad_pops", n_pops, 5);
      check("bad_cfg_period", cfg_period, 1);
      check("bad_cfg_interval", cfg_interval, 10);
      check("bad_busy", busy, 0);
`ifdef SEQ_ERR_CNT_EN
      check("bad_err_cnt", err_cnt, 3);
`endif

      // Range edges: 9 and 19 accepted, 20 rejected.
      n_pops = 0;
      push_byte(8'h02); push_byte(8'h09);
      push_byte(8'h01); push_byte(8'h13);
      push_byte(8'h01); push_byte(8'h14);
      ncyc(25);
      check("edge_pops", n_pops, 6);
      check("edge_cfg_period_9", cfg_period, 9);
      check("edge_cfg_interval_19", cfg_interval, 19);
`ifdef SEQ_ERR_CNT_EN
      check("edge_err_cnt", err_cnt, 4);
`endif

      ncyc(5);
      check("expected_events_left", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
